// File: rtl/usart_comparator.sv
// Registered one-hot magnitude comparator (equal / greater / lower), one-cycle latency.
// Optional macro COMPARATOR_SIGNED_EN adds signed_i to select two's-complement compares.
module usart_comparator #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
`ifdef COMPARATOR_SIGNED_EN
  input  logic                  signed_i,
`endif
  input  logic [DATA_WIDTH-1:0] data_0_i,
  input  logic [DATA_WIDTH-1:0] data_1_i,
  output logic                  valid_o,
  output logic                  equal_o,
  output logic                  greater_o,
  output logic                  lower_o
);

  // Result encoding of classify(): {equal, greater, lower}
  function automatic logic [2:0] classify(input logic signed [DATA_WIDTH:0] a,
                                          input logic signed [DATA_WIDTH:0] b);
    logic [2:0] res;
    res = 3'b000;
    if (a == b) begin
      res = 3'b100;
    end else if (a > b) begin
      res = 3'b010;
    end else begin
      res = 3'b001;
    end
    return res;
  endfunction

  logic                         sign_mode;
  logic signed [DATA_WIDTH:0]   a_ext;
  logic signed [DATA_WIDTH:0]   b_ext;
  logic [2:0]                   flags_nxt;

  logic                         vld_p1;
  logic                         equal_p1;
  logic                         greater_p1;
  logic                         lower_p1;

`ifdef COMPARATOR_SIGNED_EN
  assign sign_mode = signed_i;
`else
  assign sign_mode = 1'b0;
`endif

  // One extra bit lets a single signed compare serve both modes: it carries the
  // sign in two's-complement mode and is zero (pure magnitude) otherwise.
  always_comb begin
    a_ext     = {sign_mode & data_0_i[DATA_WIDTH-1], data_0_i};
    b_ext     = {sign_mode & data_1_i[DATA_WIDTH-1], data_1_i};
    flags_nxt = classify(a_ext, b_ext);
  end

  // Stage p0 -> p1: flags update only on an accepted compare and otherwise hold
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p1     <= 1'b0;
      equal_p1   <= 1'b0;
      greater_p1 <= 1'b0;
      lower_p1   <= 1'b0;
    end else begin
      vld_p1 <= valid_i;
      if (valid_i) begin
        equal_p1   <= flags_nxt[2];
        greater_p1 <= flags_nxt[1];
        lower_p1   <= flags_nxt[0];
      end
    end
  end

  assign valid_o   = vld_p1;
  assign equal_o   = equal_p1;
  assign greater_o = greater_p1;
  assign lower_o   = lower_p1;

endmodule

// File: tb/tb_usart_comparator.sv
// Self-checking bench for usart_comparator: cycle-by-cycle reference model plus literal checks.
module tb_usart_comparator;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          sgn = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          valid_o, equal_o, greater_o, lower_o;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  // Model state: {valid, equal, greater, lower}
  logic [3:0] m = 4'b0000;

  usart_comparator #(.DATA_WIDTH(DW)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .valid_i   (valid),
`ifdef COMPARATOR_SIGNED_EN
    .signed_i  (sgn),
`endif
    .data_0_i  (a),
    .data_1_i  (b),
    .valid_o   (valid_o),
    .equal_o   (equal_o),
    .greater_o (greater_o),
    .lower_o   (lower_o)
  );

  always #5 clk = ~clk;

  wire [3:0] outs = {valid_o, equal_o, greater_o, lower_o};

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got {vld,eq,gt,lt}=%b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference: what a compare of the sampled operands must yield
  function automatic logic [2:0] golden(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                        input logic s);
    logic gt, lt;
    if (s) begin
      gt = $signed(x) > $signed(y);
      lt = $signed(x) < $signed(y);
    end else begin
      gt = x > y;
      lt = x < y;
    end
    return {x == y, gt, lt};
  endfunction

  always @(negedge rst_n) m = 4'b0000;

  always @(posedge clk) begin
    if (!rst_n) begin
      m = 4'b0000;
    end else begin
      m[3] = valid;
      if (valid) m[2:0] = golden(a, b, sgn);
    end
    #1;
    if (checking) chk("model", outs, m);
  end

  task automatic drive(input logic v, input logic [DW-1:0] x, input logic [DW-1:0] y);
    @(negedge clk);
    valid = v;
    a     = x;
    b     = y;
  endtask

  task automatic post(input string name, input logic [3:0] exp);
    @(posedge clk);
    #2;
    chk(name, outs, exp);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", outs, 4'b0000);
    @(negedge clk);
    rst_n    = 1'b1;
    checking = 1'b1;

    // Basic one-hot, back-to-back
    drive(1'b1, 32'd5, 32'd9);  post("basic_lower",   4'b1001);
    drive(1'b1, 32'd9, 32'd5);  post("basic_greater", 4'b1010);
    drive(1'b1, 32'd7, 32'd7);  post("basic_equal",   4'b1100);

    // Extremes and single-bit differences
    drive(1'b1, 32'hFFFF_FFFF, 32'h0);         post("ones_vs_zero", 4'b1010);
    drive(1'b1, 32'h8000_0000, 32'h7FFF_FFFF); post("msb_split",    4'b1010);
    drive(1'b1, 32'h0, 32'h0);                 post("zero_equal",   4'b1100);
    drive(1'b1, 32'h0, 32'h1);                 post("lsb_lower",    4'b1001);
    drive(1'b1, 32'h0, 32'hFFFF_FFFF);         post("zero_vs_ones", 4'b1001);
    drive(1'b1, 32'h8000_0000, 32'h0);         post("msb_only",     4'b1010);

    // Hold: flags keep last result, valid drops
    drive(1'b1, 32'd3, 32'd1);  post("hold_setup", 4'b1010);
    drive(1'b0, 32'd0, 32'd10); post("hold_1",     4'b0010);
    drive(1'b0, 32'd20, 32'd10); post("hold_2",    4'b0010);

`ifdef COMPARATOR_SIGNED_EN
    @(negedge clk); sgn = 1'b1; valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'd1;
    post("signed_minus1_lt_1", 4'b1001);
    @(negedge clk); sgn = 1'b0;
    post("unsigned_ones_gt_1", 4'b1010);
    @(negedge clk); sgn = 1'b1; a = 32'h8000_0000; b = 32'h7FFF_FFFF;
    post("signed_min_lt_max", 4'b1001);
    @(negedge clk); sgn = 1'b0; valid = 1'b0;
`endif

    // Reset mid-operation with valid high
    drive(1'b1, 32'd1, 32'd2); post("pre_reset", 4'b1001);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs, 4'b0000);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) post("post_reset_idle", 4'b0000);

    // Random compares, one per cycle; equal operands forced sometimes
    for (int i = 0; i < 100; i++) begin
      logic [DW-1:0] x, y;
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      if ($urandom_range(0, 7) == 0) y = x ^ 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) y = x ^ 32'h1;
      drive(1'b1, x, y);
`ifdef COMPARATOR_SIGNED_EN
      sgn = 1'($urandom_range(0, 1));
`endif
    end
    // Random mix with idle cycles to exercise holding
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    drive(1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #3;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
